// File: rtl/reram_pkg.sv
// Shared definitions for the ReRAM Wishbone bridge: FSM states, register map,
// STATUS bit positions and the timeout read pattern.
package reram_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [7:0] OFF_DATA   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_CLEAR  = 8'h08;

   localparam int ST_BUSY  = 0;
   localparam int ST_OCC   = 1;
   localparam int ST_OCC_W = 6;
   localparam int ST_FULL  = 7;
   localparam int ST_EMPTY = 8;
   localparam int ST_TMO   = 9;
   localparam int ST_OVF   = 10;
   localparam int ST_UNF   = 11;

   localparam logic [31:0] TIMEOUT_PAT = 32'hDEAD_0BAD;

endpackage

// File: rtl/reram_wb_bridge.sv
// Wishbone classic slave fronting a ReRAM core: DATA port forwards one core
// request per access, plus STATUS/CLEAR registers and queue-occupancy tracking.
module reram_wb_bridge
   import reram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TIMEOUT   = 64,
   parameter int          DEPTH     = 32
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        EN,
   output logic        R_WB,
   output logic [31:0] core_dat_o,
   input  logic [31:0] core_rdata_i,
   input  logic        core_ack_i
);

   localparam int OW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state, state_nx;
   logic [OW-1:0] occ;
   logic [TW-1:0] tcnt;
   logic          flag_tmo, flag_ovf, flag_unf;
   logic          active, hit, full, empty, legal, tmo_hit;
   logic [7:0]    off;
   logic [31:0]   status, resp_dat;
   logic          set_tmo, set_ovf, set_unf, occ_inc, occ_dec;
   logic [2:0]    clr;
   logic          unused_sel;

   // Byte lanes are not supported; every access is treated as a full word.
   assign unused_sel = ^wbs_sel_i;

   assign active  = wbs_cyc_i & wbs_stb_i;
   assign hit     = active & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off     = wbs_adr_i[7:0];
   assign full    = (occ == OW'(DEPTH));
   assign empty   = (occ == '0);
   assign legal   = wbs_we_i ? !full : !empty;
   assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));

   always_comb begin
      status                      = '0;
      status[ST_BUSY]             = (state != IDLE);
      status[ST_OCC +: ST_OCC_W]  = ST_OCC_W'(occ);
      status[ST_FULL]             = full;
      status[ST_EMPTY]            = empty;
      status[ST_TMO]              = flag_tmo;
      status[ST_OVF]              = flag_ovf;
      status[ST_UNF]              = flag_unf;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      EN       = 1'b0;
      resp_dat = '0;
      set_tmo  = 1'b0;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      occ_inc  = 1'b0;
      occ_dec  = 1'b0;
      clr      = '0;
      case (state)
         IDLE: begin
            if (hit) begin
               state_nx = RESP;
               if (off == OFF_DATA) begin
                  if (legal) state_nx = REQ;
                  else begin
                     set_ovf = wbs_we_i;
                     set_unf = !wbs_we_i;
                  end
               end else begin
                  if (off == OFF_STATUS && !wbs_we_i) resp_dat = status;
                  if (off == OFF_CLEAR && wbs_we_i)   clr = wbs_dat_i[ST_UNF:ST_TMO];
               end
            end
         end
         REQ: begin
            EN       = 1'b1;
            state_nx = active ? WAIT : IDLE;
         end
         WAIT: begin
            EN = 1'b1;
            // An abandoned cycle wins over a same-cycle core ack.
            if (!active) state_nx = IDLE;
            else if (core_ack_i) begin
               state_nx = RESP;
               resp_dat = core_rdata_i;
               occ_inc  = !R_WB && !full;
               occ_dec  = R_WB && !empty;
            end else if (tmo_hit) begin
               state_nx = RESP;
               resp_dat = TIMEOUT_PAT;
               set_tmo  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o  <= 1'b0;
         wbs_dat_o  <= '0;
         R_WB       <= 1'b0;
         core_dat_o <= '0;
         tcnt       <= '0;
         occ        <= '0;
         flag_tmo   <= 1'b0;
         flag_ovf   <= 1'b0;
         flag_unf   <= 1'b0;
      end else begin
         // RESP always returns to IDLE, so this pulses for exactly one cycle.
         wbs_ack_o <= (state_nx == RESP);
         wbs_dat_o <= (state_nx == RESP) ? resp_dat : '0;
         if (state == IDLE && state_nx == REQ) begin
            R_WB       <= !wbs_we_i;
            core_dat_o <= wbs_dat_i;
         end
         if (state == REQ)       tcnt <= '0;
         else if (state == WAIT) tcnt <= tcnt + TW'(1);
         if (occ_inc)      occ <= occ + OW'(1);
         else if (occ_dec) occ <= occ - OW'(1);
         flag_tmo <= set_tmo | (flag_tmo & ~clr[0]);
         flag_ovf <= set_ovf | (flag_ovf & ~clr[1]);
         flag_unf <= set_unf | (flag_unf & ~clr[2]);
      end
   end

endmodule

// File: tb/tb_reram_wb_bridge.sv
// Randomized self-checking bench for reram_wb_bridge with a behavioural core
// responder and a queue-occupancy / sticky-flag reference model.
module tb_reram_wb_bridge;

   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          TMO   = 64;
   localparam int          DEPTH = 32;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
   logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
   logic [3:0]  wbs_sel_i = 4'hF;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        EN, R_WB;
   logic [31:0] core_dat_o;
   logic [31:0] core_rdata_i = '0;
   logic        core_ack_i = 1'b0;

   always #5 wb_clk_i = ~wb_clk_i;

   reram_wb_bridge #(.BASE_ADDR(BASE), .TIMEOUT(TMO), .DEPTH(DEPTH)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .EN(EN), .R_WB(R_WB), .core_dat_o(core_dat_o),
      .core_rdata_i(core_rdata_i), .core_ack_i(core_ack_i)
   );

   int checks = 0, failures = 0;
   int cycle = 0, ack_count = 0, ack_cyc = 0, cack_cyc = 0, datz_bad = 0;
   int en_cnt = 0, last_run = 0, en_rises = 0;
   logic        en_rwb = 1'b0;
   logic [31:0] en_dat = '0;
   int          core_delay = 10;
   bit          silent = 0, man_mode = 0, man_ack = 0;
   logic [31:0] core_rval = '0;

   int ref_occ = 0;
   bit ref_tmo = 0, ref_ovf = 0, ref_unf = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Core responder: acks in EN cycle core_delay+1, i.e. core_delay cycles after EN rises.
   always @(negedge wb_clk_i) begin
      cycle++;
      if (EN === 1'b1) begin
         en_cnt++;
         if (en_cnt == 1) begin
            en_rises++;
            en_rwb = R_WB;
            en_dat = core_dat_o;
         end
      end else begin
         if (en_cnt > 0) last_run = en_cnt;
         en_cnt = 0;
      end
      core_ack_i   = man_mode ? man_ack : (EN === 1'b1 && !silent && en_cnt == core_delay + 1);
      core_rdata_i = core_rval;
      if (core_ack_i) cack_cyc = cycle;
      if (wbs_ack_o === 1'b1) begin
         ack_count++;
         ack_cyc = cycle;
      end
      if (!wb_rst_i && wbs_ack_o === 1'b0 && wbs_dat_o !== 32'h0) datz_bad++;
   end

   task automatic tick();
      @(negedge wb_clk_i);
      #1;
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s      = '0;
      s[6:1] = ref_occ[5:0];
      s[7]   = (ref_occ == DEPTH);
      s[8]   = (ref_occ == 0);
      s[9]   = ref_tmo;
      s[10]  = ref_ovf;
      s[11]  = ref_unf;
      return s;
   endfunction

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic [31:0] rd, output bit got);
      int a0;
      a0 = ack_count;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;
      got = 0; rd = '0;
      for (int i = 0; i < 200 && !got; i++) begin
         tick();
         if (wbs_ack_o === 1'b1) begin
            got = 1;
            rd  = wbs_dat_o;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      tick();
      chk("one_ack", ack_count - a0, 1);
   endtask

   task automatic rd_status(output logic [31:0] st);
      bit got;
      wb_xfer(1'b0, BASE + 32'h4, $urandom, st, got);
      chk("status_ack", 32'(got), 1);
      chk("status", st, exp_status());
   endtask

   task automatic clr_flags(input logic [31:0] bits);
      logic [31:0] rd;
      bit got;
      wb_xfer(1'b1, BASE + 32'h8, bits, rd, got);
      chk("clr_ack", 32'(got), 1);
      if (bits[9])  ref_tmo = 0;
      if (bits[10]) ref_ovf = 0;
      if (bits[11]) ref_unf = 0;
   endtask

   task automatic data_op(input logic we, input logic [31:0] wdat, input int dly);
      logic [31:0] rd;
      bit got, legal;
      int r0;
      legal      = we ? (ref_occ < DEPTH) : (ref_occ > 0);
      core_delay = dly;
      silent     = 0;
      core_rval  = $urandom;
      r0         = en_rises;
      wb_xfer(we, BASE, wdat, rd, got);
      chk("data_ack", 32'(got), 1);
      if (legal) begin
         chk("en_pulses", en_rises - r0, 1);
         chk("en_len", last_run, dly + 1);
         chk("ack_lat", ack_cyc - cack_cyc, 1);
         chk("r_wb", 32'(en_rwb), 32'(!we));
         chk("core_dat", en_dat, wdat);
         if (!we) chk("rdata", rd, core_rval);
         ref_occ += we ? 1 : -1;
      end else begin
         chk("no_en", en_rises - r0, 0);
         if (!we) begin
            chk("unf_dat", rd, 0);
            ref_unf = 1;
         end else ref_ovf = 1;
      end
   endtask

   initial begin
      #800000;
      chk("watchdog", 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [31:0] st, rd;
      bit got;
      int a0, r0;

      repeat (3) tick();
      chk("rst_en", 32'(EN), 0);
      chk("rst_rwb", 32'(R_WB), 0);
      chk("rst_cdat", core_dat_o, 0);
      chk("rst_ack", 32'(wbs_ack_o), 0);
      chk("rst_dat", wbs_dat_o, 0);
      wb_rst_i = 1'b0;
      tick();
      rd_status(st);
      chk("status_reset", st, 32'h0000_0100);

      // Directed write then long read.
      data_op(1'b1, 32'h0A30_00A5, 10);
      chk("cdat_held", core_dat_o, 32'h0A30_00A5);
      rd_status(st);
      chk("occ_one", 32'(st[6:1]), 1);
      core_delay = 44;
      silent     = 0;
      core_rval  = 32'h0000_00A5;
      r0 = en_rises;
      wb_xfer(1'b0, BASE, 32'h0, rd, got);
      chk("rd_a5", rd, 32'h0000_00A5);
      chk("rd_en45", last_run, 45);
      chk("rd_en_once", en_rises - r0, 1);
      ref_occ = 0;
      rd_status(st);

      // Underflow, then clear it.
      data_op(1'b0, $urandom, 5);
      rd_status(st);
      clr_flags(32'h0000_0800);
      rd_status(st);

      // Randomized mix.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       rd_status(st);
            1:       clr_flags($urandom & 32'h0000_0E00);
            default: data_op(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 50)));
         endcase
      end
      rd_status(st);

      // Fill to DEPTH, then overflow.
      clr_flags(32'h0000_0E00);
      while (ref_occ < DEPTH) data_op(1'b1, $urandom, int'($urandom_range(1, 4)));
      data_op(1'b1, $urandom, 3);
      rd_status(st);
      chk("status_full", st, 32'h0000_04C0);

      // Silent core -> timeout.
      silent = 1;
      wb_xfer(1'b0, BASE, 32'h0, rd, got);
      chk("tmo_ack", 32'(got), 1);
      chk("tmo_dat", rd, 32'hDEAD_0BAD);
      chk("tmo_len", last_run, TMO + 1);
      ref_tmo = 1;
      silent  = 0;
      rd_status(st);
      clr_flags(32'h0000_0200);
      rd_status(st);
      chk("tmo_cleared", 32'(st[9]), 0);

      // Abandon a read during WAIT; late core ack must be ignored.
      silent = 1;
      a0 = ack_count;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = BASE; wbs_dat_i = $urandom;
      for (int i = 0; i < 10 && EN !== 1'b1; i++) tick();
      chk("drop_en_up", 32'(EN), 1);
      repeat (5) tick();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      tick();
      chk("drop_en_low", 32'(EN), 0);
      man_mode = 1; man_ack = 1;
      tick(); tick();
      man_ack = 0; man_mode = 0;
      repeat (3) tick();
      chk("drop_no_ack", ack_count - a0, 0);
      silent = 0;
      rd_status(st);

      // Reset during WAIT.
      silent = 1;
      a0 = ack_count;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = BASE; wbs_dat_i = 32'h1234_5678;
      for (int i = 0; i < 10 && EN !== 1'b1; i++) tick();
      repeat (3) tick();
      wb_rst_i = 1'b1;
      tick();
      chk("wrst_en", 32'(EN), 0);
      chk("wrst_rwb", 32'(R_WB), 0);
      chk("wrst_cdat", core_dat_o, 0);
      chk("wrst_ack", 32'(wbs_ack_o), 0);
      chk("wrst_dat", wbs_dat_o, 0);
      wb_rst_i = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      tick();
      chk("wrst_no_ack", ack_count - a0, 0);
      silent = 0;
      ref_occ = 0; ref_tmo = 0; ref_ovf = 0; ref_unf = 0;
      rd_status(st);
      chk("status_after_rst", st, 32'h0000_0100);

      // Outside the window: no response at all.
      a0 = ack_count;
      r0 = en_rises;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_adr_i = 32'h4000_0000; wbs_dat_i = $urandom;
      repeat (6) tick();
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      tick();
      chk("miss_no_ack", ack_count - a0, 0);
      chk("miss_no_en", en_rises - r0, 0);

      // Unmapped offset and CLEAR read return zero; unmapped write is discarded.
      wb_xfer(1'b0, BASE + 32'h10, 32'h0, rd, got);
      chk("unmapped_rd", rd, 0);
      wb_xfer(1'b0, BASE + 32'h8, 32'h0, rd, got);
      chk("clear_rd", rd, 0);
      wb_xfer(1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, rd, got);
      rd_status(st);

      chk("dat_zero_idle", datz_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
